mul_div_unit: RTL

- Multi-cycle execution unit for RV32M operations.
- Consumes decoded ops that the decode stage has marked isMulDiv, together with their mulDivCode and two register operands.
- Sits in the execute stage beside the ALU. It asserts a busy signal so the pipeline holds issue while an operation is in flight.
- Produces one 32-bit result, with a one-cycle valid pulse, for writeback.

---
 rtl/mul_div_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle RV32M execution unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). Single-cycle multiply, restoring divider with one
// quotient bit per cycle, special-case divide results, flush abort.
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  reqValid,
   input  logic [2:0]            reqCode,
   input  logic [DATA_WIDTH-1:0] reqOp1,
   input  logic [DATA_WIDTH-1:0] reqOp2,
   input  logic                  flush,
   output logic                  reqReady,
   output logic                  busy,
   output logic                  resValid,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE, MUL, DIV, DIVSPEC, DONE
   } state_e;

   typedef enum logic [2:0] {
      C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU
   } code_e;

   state_e          state;
   code_e           code;
   logic [W-1:0]    op1, op2;
   logic [W-1:0]    dvs, quo, rem;
   logic [CW-1:0]   cnt;
   logic            negQ, negR;
   logic            doneV;

   logic            accept;
   logic            reqIsDiv, reqSigned, reqDivZero, reqOvf, reqNegA, reqNegB;
   logic [W-1:0]    absA, absB;
   logic            sA, sB;
   logic [2*W-1:0]  mA, mB, prod;
   logic [W-1:0]    mulRes;
   logic [W:0]      shifted;
   logic [W-1:0]    diff;
   logic            fits;
   logic            isRem;
   logic [W-1:0]    quoFix, remFix, specRes;

   // request decode: classify the incoming op and form operand magnitudes
   always_comb begin
      accept     = reqValid & reqReady & ~flush;
      reqIsDiv   = reqCode[2];
      reqSigned  = (reqCode == C_DIV) || (reqCode == C_REM);
      reqDivZero = (reqOp2 == '0);
      reqOvf     = reqSigned && (reqOp1 == {1'b1, {(W-1){1'b0}}}) && (reqOp2 == '1);
      reqNegA    = reqSigned & reqOp1[W-1];
      reqNegB    = reqSigned & reqOp2[W-1];
      absA       = reqNegA ? -reqOp1 : reqOp1;
      absB       = reqNegB ? -reqOp2 : reqOp2;
   end

   // datapath: product, one restoring-division step, sign fix-up, special cases
   always_comb begin
      sA      = (code != C_MULHU);
      sB      = (code == C_MUL) || (code == C_MULH);
      mA      = {{W{sA & op1[W-1]}}, op1};
      mB      = {{W{sB & op2[W-1]}}, op2};
      prod    = mA * mB;
      mulRes  = (code == C_MUL) ? prod[W-1:0] : prod[2*W-1:W];
      shifted = {rem, quo[W-1]};
      fits    = (shifted >= {1'b0, dvs});
      // when the trial subtract succeeds the true difference is below dvs,
      // so the low W bits of a W-bit subtract are exact
      diff    = shifted[W-1:0] - dvs;
      isRem   = (code == C_REM) || (code == C_REMU);
      quoFix  = negQ ? -quo : quo;
      remFix  = negR ? -rem : rem;
      if (op2 == '0) specRes = isRem ? op1 : '1;
      else           specRes = isRem ? '0 : op1;
   end

   // control FSM with registered status and result
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state    <= IDLE;
         code     <= C_MUL;
         op1      <= '0;
         op2      <= '0;
         dvs      <= '0;
         quo      <= '0;
         rem      <= '0;
         cnt      <= '0;
         negQ     <= 1'b0;
         negR     <= 1'b0;
         doneV    <= 1'b0;
         reqReady <= 1'b1;
         busy     <= 1'b0;
         result   <= '0;
      end else begin
         doneV <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  code     <= code_e'(reqCode);
                  op1      <= reqOp1;
                  op2      <= reqOp2;
                  negQ     <= reqNegA ^ reqNegB;
                  negR     <= reqNegA;
                  quo      <= absA;
                  dvs      <= absB;
                  rem      <= '0;
                  cnt      <= CW'(W);
                  reqReady <= 1'b0;
                  busy     <= 1'b1;
                  if (!reqIsDiv)                 state <= MUL;
                  else if (reqDivZero || reqOvf) state <= DIVSPEC;
                  else                           state <= DIV;
               end
            end
            MUL: begin
               result <= mulRes;
               doneV  <= 1'b1;
               state  <= DONE;
            end
            DIV: begin
               if (cnt != '0) begin
                  rem <= fits ? diff : shifted[W-1:0];
                  quo <= {quo[W-2:0], fits};
                  cnt <= cnt - CW'(1);
               end else begin
                  result <= isRem ? remFix : quoFix;
                  doneV  <= 1'b1;
                  state  <= DONE;
               end
            end
            DIVSPEC: begin
               result <= specRes;
               doneV  <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               state    <= IDLE;
               reqReady <= 1'b1;
               busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         // flush wins over everything above: abort, keep the old result
         if (flush && state != IDLE) begin
            state    <= IDLE;
            reqReady <= 1'b1;
            busy     <= 1'b0;
            doneV    <= 1'b0;
            result   <= result;
         end
      end
   end

   // a flush arriving during DONE still kills the pulse
   assign resValid = doneV & ~flush;

endmodule
